// File: rtl/rec_byte_serializer_if.sv
// rec_byte_serializer_if
//   Word-level valid/ready input bus of the record byte serializer.
//
//   Handshake: the producer holds i_data stable with i_valid high; a word
//   transfers on every rising clock edge where i_valid && o_ready. i_data is
//   ignored on any edge where it does not transfer. o_ready does not depend
//   on i_valid.
//
//   Signals:
//     i_data   DATA_W  payload word          (master -> slave)
//     i_valid  1       i_data is valid       (master -> slave)
//     o_ready  1       slave accepts i_data  (slave  -> master)
interface rec_byte_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/rec_byte_serializer.sv
// rec_byte_serializer
//   Buffers record payload words in a small circular FIFO and sends each one
//   as a serial frame on o_ser: start bit (0), DATA_W data bits LSB first,
//   optional even-parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//   Frames stream back to back while words are queued.
//
//   Optional feature: define REC_SER_PARITY_EN to insert a PARITY bit
//   (XOR of the payload) between the last data bit and the stop bit.
//
//   Ports:
//     i_clk         clock, rising edge
//     i_rst_n       synchronous active-low reset
//     bus           slave side of the i_data/i_valid/o_ready handshake
//     o_ser         serial line, idles high
//     o_busy        a frame is in progress (START/DATA/PARITY/STOP)
//     o_frame_done  one-cycle pulse on the last cycle of a stop bit
//     o_level       FIFO occupancy
//     o_state       current FSM state (debug visibility)
module rec_byte_serializer #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    rec_byte_serializer_if.slave          bus,
    output logic                          o_ser,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic [2:0]                    o_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef REC_SER_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    // FIFO storage and pointers; depth is a power of two so pointers wrap
    // naturally.
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [BIT_W-1:0]  bit_idx, bit_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              cnt_last;
    logic              bit_last;
    logic              ser_n;
    logic              busy_n;
    logic              done_n;
`ifdef REC_SER_PARITY_EN
    logic              par, par_n;
`endif

    // Ready decodes only the registered level, so a full FIFO refuses a push
    // even on an edge where the FSM pops.
    assign bus.o_ready = (o_level < LVL_W'(FIFO_DEPTH));
    assign push        = bus.i_valid && bus.o_ready;
    assign head        = mem[rd_ptr];
    assign cnt_last    = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign bit_last    = (bit_idx == BIT_W'(DATA_W - 1));
    assign o_state     = state;

    always_ff @(posedge i_clk) begin
        if (i_rst_n && push) begin
            mem[wr_ptr] <= bus.i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   o_level <= o_level + LVL_W'(1);
                2'b01:   o_level <= o_level - LVL_W'(1);
                default: o_level <= o_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            o_ser        <= 1'b1;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
`ifdef REC_SER_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_n;
            shift        <= shift_n;
            o_ser        <= ser_n;
            o_busy       <= busy_n;
            o_frame_done <= done_n;
`ifdef REC_SER_PARITY_EN
            par          <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
`ifdef REC_SER_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                if (o_level != '0) begin
                    pop     = 1'b1;
                    shift_n = head;
                    cnt_n   = '0;
                    state_n = START;
`ifdef REC_SER_PARITY_EN
                    par_n   = ^head;
`endif
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_n   = '0;
                    shift_n = shift >> 1;
                    if (bit_last) begin
`ifdef REC_SER_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_idx + BIT_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`ifdef REC_SER_PARITY_EN
            PARITY: begin
                if (cnt_last) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_last) begin
                    cnt_n = '0;
                    // Chain straight into the next frame when a word waits.
                    if (o_level != '0) begin
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = START;
`ifdef REC_SER_PARITY_EN
                        par_n   = ^head;
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered: decode them from the next-state values.
    always_comb begin
        ser_n = 1'b1;
        case (state_n)
            START:   ser_n = 1'b0;
            DATA:    ser_n = shift_n[0];
`ifdef REC_SER_PARITY_EN
            PARITY:  ser_n = par_n;
`endif
            default: ser_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
        done_n = (state_n == STOP) && (cnt_n == CNT_W'(CLKS_PER_BIT - 1));
    end
endmodule

// File: tb/tb_rec_byte_serializer.sv
// tb_rec_byte_serializer
//   Self-checking bench for rec_byte_serializer: a table of single frames,
//   then back-to-back streaming, pointer wrap and a mid-frame reset. A frame
//   monitor checks every serial cycle against the word queue.
module tb_rec_byte_serializer;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef REC_SER_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int FRAME = NB * CPB;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             o_ser;
    logic             o_busy;
    logic             o_frame_done;
    logic [LVL_W-1:0] o_level;
    logic [2:0]       o_state;

    rec_byte_serializer_if #(.DATA_W(DW)) bus ();

    rec_byte_serializer #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_ser       (o_ser),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done),
        .o_level     (o_level),
        .o_state     (o_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [DW-1:0] w, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
`ifdef REC_SER_PARITY_EN
        if (b == DW + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    // ---------------- frame monitor ----------------
    bit            rx_active = 0;
    int            rx_k      = 0;
    logic [DW-1:0] rx_word   = '0;
    int            gap       = 0;
    bit            prev_end  = 0;
    bit            b2b_mode  = 0;
    int            max_level = 0;

    always @(posedge clk) begin
        logic             rst_s;
        logic             acc;
        logic [DW-1:0]    acc_d;
        logic [LVL_W-1:0] lvl_pre;
        rst_s   = rst_n;
        acc     = bus.i_valid && bus.o_ready;
        acc_d   = bus.i_data;
        lvl_pre = o_level;
        #1;
        if (!rst_s) begin
            exp_q.delete();
            rx_active = 0;
            prev_end  = 0;
            gap       = 0;
        end else begin
            if (int'(lvl_pre) == DEPTH) check("no_push_when_full", acc, 0);
            if (acc) exp_q.push_back(acc_d);
            if (!rx_active) begin
                if (o_ser == 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        rx_word = exp_q.pop_front();
                        if (b2b_mode && prev_end) check("b2b_gap", gap, 0);
                        rx_active = 1;
                        rx_k      = 0;
                    end
                end else begin
                    check("idle_busy", o_busy, 0);
                    check("idle_frame_done", o_frame_done, 0);
                    gap++;
                end
            end
            if (rx_active) begin
                check("ser_bit", o_ser, exp_bit(rx_word, rx_k));
                check("frame_busy", o_busy, 1);
                check("frame_done_pulse", o_frame_done, (rx_k == FRAME - 1));
                rx_k++;
                if (rx_k == FRAME) begin
                    rx_active = 0;
                    gap       = 0;
                    prev_end  = 1;
                end
            end
            check("level", o_level, exp_q.size());
            check("ready", bus.o_ready, (exp_q.size() < DEPTH));
            if (int'(o_level) > max_level) max_level = int'(o_level);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_capture(input logic [DW-1:0] d, output logic [NB-1:0] seq,
                                output int done_k, output int done_n, output logic busy_after);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_data  = DW'($urandom_range(0, 255));
        seq    = '0;
        done_k = -1;
        done_n = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(posedge clk);
            #1;
            if (k % CPB == 0) seq[NB-1-(k/CPB)] = o_ser;
            if (o_frame_done) begin
                done_n++;
                done_k = k;
            end
        end
        @(posedge clk);
        #1;
        busy_after = o_busy;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rx_active && !o_busy) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [9:0]    seq;   // start, data LSB first, stop (first bit in MSB)
        logic          par;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [NB-1:0] got;
        logic [NB-1:0] exp_seq;
        int            done_k;
        int            done_n;
        logic          busy_after;
        int            idx;
        logic          r;
        bit            ok;

        vecs[0] = '{data: 8'hA5, seq: 10'b0_10100101_1, par: 1'b0};
        vecs[1] = '{data: 8'h00, seq: 10'b0_00000000_1, par: 1'b0};
        vecs[2] = '{data: 8'hFF, seq: 10'b0_11111111_1, par: 1'b0};
        vecs[3] = '{data: 8'h3C, seq: 10'b0_00111100_1, par: 1'b0};
        vecs[4] = '{data: 8'h01, seq: 10'b0_10000000_1, par: 1'b1};
        vecs[5] = '{data: 8'h07, seq: 10'b0_11100000_1, par: 1'b1};
        vecs[6] = '{data: 8'h03, seq: 10'b0_11000000_1, par: 1'b0};

        // ---- reset with i_valid held high ----
        rst_n       = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h55;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_ser", o_ser, 1);
            check("rst_busy", o_busy, 0);
            check("rst_level", o_level, 0);
            check("rst_ready", bus.o_ready, 1);
            check("rst_done", o_frame_done, 0);
            check("rst_state", o_state, 0);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        bus.i_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_level", o_level, 0);
        check("post_rst_busy", o_busy, 0);

        // ---- table: one isolated frame per entry ----
        foreach (vecs[i]) begin
`ifdef REC_SER_PARITY_EN
            exp_seq = {vecs[i].seq[9:1], vecs[i].par, 1'b1};
`else
            exp_seq = vecs[i].seq;
`endif
            send_capture(vecs[i].data, got, done_k, done_n, busy_after);
            check($sformatf("seq_%02h", vecs[i].data), got, exp_seq);
            check($sformatf("done_cycle_%02h", vecs[i].data), done_k, FRAME - 1);
            check($sformatf("done_count_%02h", vecs[i].data), done_n, 1);
            check($sformatf("busy_fall_%02h", vecs[i].data), busy_after, 0);
            repeat (2) @(negedge clk);
        end
        drain("table_drain");

        // ---- back-to-back: valid held high with 0x01..0x06 ----
        b2b_mode  = 1;
        prev_end  = 0;
        max_level = 0;
        idx       = 1;
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = DW'(idx);
        for (int t = 0; t < 2000 && idx <= 6; t++) begin
            r = bus.o_ready;
            @(negedge clk);
            if (r) begin
                idx++;
                if (idx > 6) bus.i_valid = 1'b0;
                else bus.i_data = DW'(idx);
            end
        end
        bus.i_valid = 1'b0;
        check("b2b_all_accepted", idx, 7);
        drain("b2b_drain");
        check("b2b_max_level", max_level, DEPTH);
        b2b_mode = 0;

        // ---- pointer wrap: 10 words with random gaps ----
        for (int i = 0; i < 10; i++) begin
            ok = 0;
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.i_data  = DW'(8'h10 + i);
            for (int t = 0; t < 400; t++) begin
                if (bus.o_ready) begin
                    ok = 1;
                    break;
                end
                @(negedge clk);
            end
            check("wrap_accept", ok, 1);
            @(negedge clk);
            bus.i_valid = 1'b0;
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        drain("wrap_drain");

        // ---- reset during DATA bit 3 of 0x3C with two words queued ----
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h3C;
        @(negedge clk);
        bus.i_data  = 8'h40;
        @(negedge clk);
        bus.i_data  = 8'h41;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_state_before", o_state, 2);
        check("midrst_level_before", o_level, 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ser", o_ser, 1);
        check("midrst_level", o_level, 0);
        check("midrst_busy", o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("midrst_quiet_level", o_level, 0);
        check("midrst_quiet_busy", o_busy, 0);
        check("midrst_quiet_ser", o_ser, 1);

        // ---- report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end
endmodule
